burst_ram: RTL and testbench

BURST_RAM -- requirements
Module: burst_ram

---
 rtl/burst_ram.sv | 179 +++++++++++++++++
 tb/tb_burst_ram.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/burst_ram.sv
// Burst RAM model: 64-bit words, fixed 4-beat bursts, calibration delay and command spacing.
// Optional `BURST_RAM_CMD_CHECK_EN adds a sticky cmd_error flag for commands that were ignored.
module burst_ram #(
    parameter int ADDRESS_BITWIDTH = 21,
    parameter int READ_LATENCY     = 8,
    parameter int COMMAND_INTERVAL = 14,
    parameter int INIT_CYCLES      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd,
    input  logic                        cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0] addr,
    input  logic [63:0]                 wr_data,
    input  logic [7:0]                  data_mask,
    output logic [63:0]                 rd_data,
    output logic                        rd_data_valid,
    output logic                        init_calib,
    output logic                        cmd_error
);

    localparam int WORD_AW = ADDRESS_BITWIDTH - 3;
    localparam int DEPTH   = 1 << WORD_AW;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   init_cnt_q;
    logic [CNT_W-1:0]   interval_q;
    logic [CNT_W-1:0]   lat_q;
    logic [1:0]         beat_q;
    logic [WORD_AW-1:0] base_q;
    logic [63:0]        rd_data_q;
    logic               rd_valid_q;
    logic               init_calib_q;

    logic [63:0]        mem [DEPTH];

    logic               accept;
    logic [WORD_AW-1:0] cmd_base;
    logic               mem_we;
    logic [WORD_AW-1:0] mem_waddr;

    // The byte offset within a word has no meaning for a 64-bit word memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[2:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cmd_base  = addr[ADDRESS_BITWIDTH-1:3];
        accept    = cmd_en && (state_q == ST_IDLE) && (interval_q == '0);
        mem_we    = 1'b0;
        mem_waddr = cmd_base;
        if (accept && cmd) begin
            mem_we = 1'b1;
        end else if (state_q == ST_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = base_q + WORD_AW'(beat_q);
        end
    end

    // NOTE: the storage array has no reset, so data written before a reset survives it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (!data_mask[k]) begin
                    mem[mem_waddr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            interval_q   <= '0;
            lat_q        <= '0;
            beat_q       <= '0;
            base_q       <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            init_calib_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (interval_q != '0) begin
                interval_q <= interval_q - CNT_W'(1);
            end

            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                        state_q      <= ST_IDLE;
                        init_calib_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + CNT_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (accept) begin
                        interval_q <= CNT_W'(COMMAND_INTERVAL - 1);
                        base_q     <= cmd_base;
                        if (cmd) begin
                            state_q <= ST_WRITE;
                            beat_q  <= 2'd1;
                        end else begin
                            // One wait edge is spent entering READ, hence the -2.
                            state_q <= ST_READ_WAIT;
                            lat_q   <= CNT_W'(READ_LATENCY - 2);
                            beat_q  <= 2'd0;
                        end
                    end
                end

                ST_WRITE: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_READ_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= ST_READ;
                        beat_q  <= 2'd0;
                    end else begin
                        lat_q <= lat_q - CNT_W'(1);
                    end
                end

                ST_READ: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= mem[base_q + WORD_AW'(beat_q)];
                    beat_q     <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_INIT;
            endcase
        end
    end

`ifdef BURST_RAM_CMD_CHECK_EN
    logic cmd_error_q;
    logic cmd_error_d;

    always_comb begin
        cmd_error_d = cmd_error_q | (cmd_en && init_calib_q && !accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_error_q <= 1'b0;
        end else begin
            cmd_error_q <= cmd_error_d;
        end
    end

    assign cmd_error = cmd_error_q;
`else
    assign cmd_error = 1'b0;
`endif

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign init_calib    = init_calib_q;

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram: calibration, bursts, masking, wrap, ignored commands, reset abort.
module tb_burst_ram;

    logic        clk;
    logic        rst_n;
    logic        cmd;
    logic        cmd_en;
    logic [20:0] addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        init_calib;
    logic        cmd_error;

    int n_checks = 0;
    int n_pass   = 0;

    burst_ram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_en       (cmd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .data_mask    (data_mask),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .init_calib   (init_calib),
        .cmd_error    (cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Accept edge plus three beat edges, then idle until the interval counter clears.
    task automatic write_burst(input logic [20:0] a,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3,
                               input logic [7:0] m0, input logic [7:0] m1,
                               input logic [7:0] m2, input logic [7:0] m3);
        cmd = 1'b1; addr = a; cmd_en = 1'b1; wr_data = d0; data_mask = m0;
        tick(1);
        cmd_en = 1'b0; wr_data = d1; data_mask = m1;
        tick(1);
        wr_data = d2; data_mask = m2;
        tick(1);
        wr_data = d3; data_mask = m3;
        tick(1);
        wr_data = '0; data_mask = '0;
        tick(10);
    endtask

    // Read accepted at edge T; beats expected after edges T+8..T+11; returns after T+13.
    task automatic read_burst(input string tag, input logic [20:0] a,
                              input logic [63:0] e0, input logic [63:0] e1,
                              input logic [63:0] e2, input logic [63:0] e3,
                              input int nchk, input bit inject);
        logic [63:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        cmd = 1'b0; addr = a; cmd_en = 1'b1;
        tick(1);
        for (int i = 1; i <= 7; i++) begin
            cmd_en = inject && (i == 5);
            tick(1);
        end
        cmd_en = 1'b0;
        check({tag, " valid before latency"}, 64'(rd_data_valid), 64'd0);
        for (int b = 0; b < 4; b++) begin
            tick(1);
            check($sformatf("%s valid beat%0d", tag, b), 64'(rd_data_valid), 64'd1);
            if (b < nchk) begin
                check($sformatf("%s data beat%0d", tag, b), rd_data, e[b]);
            end
        end
        tick(1);
        check({tag, " valid after burst"}, 64'(rd_data_valid), 64'd0);
        if (nchk == 4) begin
            check({tag, " data hold"}, rd_data, e[3]);
        end
        tick(1);
    endtask

    initial begin
        logic seen;
        logic exp_err;

        rst_n = 1'b0; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
        tick(2);
        check("reset valid", 64'(rd_data_valid), 64'd0);
        check("reset rd_data", rd_data, 64'd0);
        check("reset init_calib", 64'(init_calib), 64'd0);
        check("reset cmd_error", 64'(cmd_error), 64'd0);

        // Calibration: init_calib rises after exactly 16 edges; commands before that are dropped.
        rst_n = 1'b1; cmd = 1'b0; cmd_en = 1'b1; addr = 21'h40;
        tick(15);
        check("init_calib after 15 edges", 64'(init_calib), 64'd0);
        cmd_en = 1'b0;
        tick(1);
        check("init_calib after 16 edges", 64'(init_calib), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            seen = seen | rd_data_valid;
            tick(1);
        end
        check("no burst from init-time cmd", 64'(seen), 64'd0);
        check("no error from init-time cmd", 64'(cmd_error), 64'd0);

        write_burst(21'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                    8'h00, 8'h00, 8'h00, 8'h00);
        read_burst("rd40", 21'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4, 1'b0);

        // Low four byte lanes masked on beat 0; beats 1..3 fully masked.
        write_burst(21'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0,
                    8'h0F, 8'hFF, 8'hFF, 8'hFF);
        read_burst("mask", 21'h40, 64'hFFFF_FFFF_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4, 1'b0);

        // Write at the last word wraps beats 1..3 onto words 0..2.
        write_burst(21'h1FFFF8, 64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                    64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3,
                    8'h00, 8'h00, 8'h00, 8'h00);
        read_burst("wrap0", 21'h0, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2,
                   64'hA3A3_A3A3_A3A3_A3A3, 64'h0, 3, 1'b0);
        read_burst("wraplast", 21'h1FFFF8, 64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                   64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3, 4, 1'b0);

        // Second cmd_en five edges into a read must be ignored.
        check("cmd_error before ignored cmd", 64'(cmd_error), 64'd0);
        read_burst("inject", 21'h40, 64'hFFFF_FFFF_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | rd_data_valid;
            tick(1);
        end
        check("no extra beats after ignored cmd", 64'(seen), 64'd0);
`ifdef BURST_RAM_CMD_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("cmd_error after ignored cmd", 64'(cmd_error), 64'(exp_err));

        // Reset during read beat 2 aborts the burst but keeps memory.
        cmd = 1'b0; addr = 21'h40; cmd_en = 1'b1;
        tick(1);
        cmd_en = 1'b0;
        tick(10);
        check("abort beat2 valid", 64'(rd_data_valid), 64'd1);
        check("abort beat2 data", rd_data, 64'h3333_3333_3333_3333);
        rst_n = 1'b0;
        #1;
        check("abort valid drops", 64'(rd_data_valid), 64'd0);
        check("abort rd_data cleared", rd_data, 64'd0);
        check("abort init_calib cleared", 64'(init_calib), 64'd0);
        check("abort cmd_error cleared", 64'(cmd_error), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(15);
        check("reinit init_calib after 15", 64'(init_calib), 64'd0);
        tick(1);
        check("reinit init_calib after 16", 64'(init_calib), 64'd1);
        read_burst("post-reset", 21'h40, 64'hFFFF_FFFF_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
